// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator: pixel enable, h/v counters,
// registered sync/blank/active/coordinate outputs and start pulses.
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_pix_ce,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblank,
  output logic        o_vblank,
  output logic        o_active,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  D_MAX = 4'(CLK_DIV - 1);
  localparam logic [11:0] H_END = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_A   = 12'(H_ACTIVE);
  localparam logic [11:0] H_S0  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_S1  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_END = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_A   = 12'(V_ACTIVE);
  localparam logic [11:0] V_S0  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_S1  = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } region_t;

  logic [3:0]  d;
  logic [11:0] h;
  logic [11:0] v;
  logic        ce;
  logic        h_wrap;
  logic        v_wrap;
  region_t     h_reg;
  region_t     v_reg;
  logic        hb;
  logic        vb;
  logic        hs_on;
  logic        vs_on;

  assign ce     = (d == D_MAX);
  assign h_wrap = (h == H_END);
  assign v_wrap = (v == V_END);

  // Regions come straight from the counts; there is no state register.
  always_comb begin
    h_reg = ACTIVE;
    unique case (1'b1)
      (h < H_A):                h_reg = ACTIVE;
      (h >= H_A  && h < H_S0):  h_reg = FP;
      (h >= H_S0 && h < H_S1):  h_reg = SYNC;
      default:                  h_reg = BP;
    endcase
  end

  always_comb begin
    v_reg = ACTIVE;
    unique case (1'b1)
      (v < V_A):                v_reg = ACTIVE;
      (v >= V_A  && v < V_S0):  v_reg = FP;
      (v >= V_S0 && v < V_S1):  v_reg = SYNC;
      default:                  v_reg = BP;
    endcase
  end

  assign hb    = (h_reg != ACTIVE);
  assign vb    = (v_reg != ACTIVE);
  assign hs_on = (h_reg == SYNC);
  assign vs_on = (v_reg == SYNC);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      d             <= '0;
      h             <= '0;
      v             <= '0;
      o_pix_ce      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_hblank      <= 1'b1;
      o_vblank      <= 1'b1;
      o_active      <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      d             <= ce ? '0 : d + 4'd1;
      o_pix_ce      <= ce;
      o_line_start  <= ce && (h == '0);
      o_frame_start <= ce && (h == '0) && (v == '0);
      // Outputs carry the pixel the counters held at this enable.
      if (ce) begin
        o_x      <= h;
        o_y      <= v;
        o_hblank <= hb;
        o_vblank <= vb;
        o_active <= !hb && !vb;
        o_hsync  <= hs_on ? SYNC_POL : ~SYNC_POL;
        o_vsync  <= vs_on ? SYNC_POL : ~SYNC_POL;
        h        <= h_wrap ? '0 : h + 12'd1;
        if (h_wrap) begin
          v <= v_wrap ? '0 : v + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three geometries checked every cycle
// against a pixel-index model through a scoreboard queue.
module tb_vga_timing;

  typedef struct packed {
    logic        pce;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        act;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic        pce [3];
  logic        hs  [3];
  logic        vs  [3];
  logic        hb  [3];
  logic        vb  [3];
  logic        act [3];
  logic [11:0] xs  [3];
  logic [11:0] ys  [3];
  logic        ls  [3];
  logic        fs  [3];

  out_t sb[$];
  out_t last0;
  int   n;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing u0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_ce(pce[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_hblank(hb[0]),
    .o_vblank(vb[0]), .o_active(act[0]), .o_x(xs[0]),
    .o_y(ys[0]), .o_line_start(ls[0]), .o_frame_start(fs[0])
  );

  vga_timing #(.CLK_DIV(1), .SYNC_POL(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_ce(pce[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_hblank(hb[1]),
    .o_vblank(vb[1]), .o_active(act[1]), .o_x(xs[1]),
    .o_y(ys[1]), .o_line_start(ls[1]), .o_frame_start(fs[1])
  );

  vga_timing #(
    .CLK_DIV(3),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_ce(pce[2]),
    .o_hsync(hs[2]), .o_vsync(vs[2]), .o_hblank(hb[2]),
    .o_vblank(vb[2]), .o_active(act[2]), .o_x(xs[2]),
    .o_y(ys[2]), .o_line_start(ls[2]), .o_frame_start(fs[2])
  );

  // n = edges since release; pixel p is the last one latched.
  function automatic out_t model(
    int n, int cd,
    int ha, int hf, int hsw, int hbp,
    int va, int vf, int vsw, int vbp,
    bit pol
  );
    out_t o;
    int ht, vt, p, x, y;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    o.hb = 1'b1;
    o.vb = 1'b1;
    if (n >= cd) begin
      p = n / cd - 1;
      x = p % ht;
      y = (p / ht) % vt;
      o.pce = (n % cd == 0);
      o.x = 12'(x);
      o.y = 12'(y);
      o.hb = (x >= ha);
      o.vb = (y >= va);
      o.act = !o.hb && !o.vb;
      o.hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
      o.vs = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
      o.ls = o.pce && (x == 0);
      o.fs = o.ls && (y == 0);
    end
    return o;
  endfunction

  function automatic out_t observe(int i);
    out_t o;
    o.pce = pce[i];
    o.hs  = hs[i];
    o.vs  = vs[i];
    o.hb  = hb[i];
    o.vb  = vb[i];
    o.act = act[i];
    o.ls  = ls[i];
    o.fs  = fs[i];
    o.x   = xs[i];
    o.y   = ys[i];
    return o;
  endfunction

  task automatic step();
    out_t e;
    out_t o;
    @(posedge clk);
    if (!rst_n) n = 0;
    else n++;
    last0 = model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    sb.push_back(last0);
    sb.push_back(model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    sb.push_back(model(n, 3, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      o = observe(i);
      tests++;
      assert (o === e) else begin
        fails++;
        $error("FAIL u%0d n=%0d obs=%h exp=%h", i, n, o, e);
      end
    end
  endtask

  initial begin
    bit found;
    n = 0;
    tests = 0;
    fails = 0;
    found = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1;
    for (int k = 0; k < 4000; k++) step();
    for (int k = 0; k < 2000 && !found; k++) begin
      step();
      if (last0.pce && last0.x == 12'd300) found = 1'b1;
    end
    tests++;
    assert (found === 1'b1) else begin
      fails++;
      $error("FAIL seek_x300 obs=%0b exp=1", found);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3400; k++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
